node_endpoint_p: RTL and testbench

//  Parametrised network endpoint between the testbench packet interface and one router port.

---
 rtl/node_endpoint_p.sv | 218 +++++++++++++++++++++
 tb/tb_node_endpoint_p.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/node_endpoint_p.sv
// Network endpoint: outbound packet FIFO + flit serialiser, inbound flit deserialiser + packet FIFO.
// Optional statistics counters are enabled by defining NODE_EP_STATS_EN.

module node_ep_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [W-1:0]               wdata_i,
   output logic [W-1:0]               rdata_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          push_ok, pop_ok;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Storage is not reset; consumers gate the head with empty_o.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

module node_endpoint_p #(
   parameter int PKT_W    = 32,
   parameter int FLIT_W   = 8,
   parameter int OQ_DEPTH = 4,
   parameter int IQ_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PKT_W-1:0]  pkt_in,
   input  logic              pkt_in_avail,
   output logic              cQ_full,
   output logic [PKT_W-1:0]  pkt_out,
   output logic              pkt_out_avail,
   input  logic              pkt_out_rdy,
   input  logic              free_outbound,
   output logic              put_outbound,
   output logic [FLIT_W-1:0] payload_outbound,
   output logic              free_inbound,
   input  logic              put_inbound,
   input  logic [FLIT_W-1:0] payload_inbound,
`ifdef NODE_EP_STATS_EN
   output logic [15:0]       tx_pkt_cnt,
   output logic [15:0]       rx_pkt_cnt,
   output logic [7:0]        drop_cnt,
`endif
   output logic              tx_state_o,
   output logic              rx_state_o
);
   localparam int NFLITS = PKT_W / FLIT_W;
   localparam int CNT_W  = $clog2(NFLITS);

   typedef enum logic {TX_IDLE = 1'b0, TX_SEND = 1'b1} tx_state_e;
   typedef enum logic {RX_IDLE = 1'b0, RX_RECV = 1'b1} rx_state_e;

   tx_state_e          tx_state_q, tx_state_d;
   rx_state_e          rx_state_q, rx_state_d;
   logic [PKT_W-1:0]   tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
   logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic               oq_pop, oq_full, oq_empty, tx_last;
   logic               iq_push, iq_full, iq_empty;
   logic [PKT_W-1:0]   oq_rdata, iq_rdata, iq_wdata;
   logic [$clog2(OQ_DEPTH):0] oq_count;
   logic [$clog2(IQ_DEPTH):0] iq_count;

   node_ep_fifo #(.W(PKT_W), .DEPTH(OQ_DEPTH)) u_oq (
      .clk(clk), .rst(rst), .push_i(pkt_in_avail), .pop_i(oq_pop), .wdata_i(pkt_in),
      .rdata_o(oq_rdata), .count_o(oq_count), .full_o(oq_full), .empty_o(oq_empty)
   );

   node_ep_fifo #(.W(PKT_W), .DEPTH(IQ_DEPTH)) u_iq (
      .clk(clk), .rst(rst), .push_i(iq_push), .pop_i(pkt_out_rdy), .wdata_i(iq_wdata),
      .rdata_o(iq_rdata), .count_o(iq_count), .full_o(iq_full), .empty_o(iq_empty)
   );

   assign cQ_full       = oq_full;
   assign pkt_out_avail = !iq_empty;
   assign pkt_out       = iq_empty ? '0 : iq_rdata;
   assign tx_state_o    = tx_state_q;
   assign rx_state_o    = rx_state_q;

   // Only RX pushes IQ and it does so from RECV, so an IDLE-time count check reserves the slot.
   assign free_inbound = (rx_state_q == RX_IDLE) && (iq_count < ($clog2(IQ_DEPTH)+1)'(IQ_DEPTH));
   assign iq_wdata     = {rx_shift_q[PKT_W-FLIT_W-1:0], payload_inbound};

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q <= TX_IDLE;
         rx_state_q <= RX_IDLE;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         tx_cnt_q   <= '0;
         rx_cnt_q   <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         rx_state_q <= rx_state_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         tx_cnt_q   <= tx_cnt_d;
         rx_cnt_q   <= rx_cnt_d;
      end
   end

   always_comb begin
      tx_state_d       = tx_state_q;
      tx_shift_d       = tx_shift_q;
      tx_cnt_d         = tx_cnt_q;
      oq_pop           = 1'b0;
      tx_last          = 1'b0;
      put_outbound     = 1'b0;
      payload_outbound = '0;
      case (tx_state_q)
         TX_IDLE: begin
            if (!oq_empty && free_outbound) begin
               oq_pop     = 1'b1;
               tx_shift_d = oq_rdata;
               tx_cnt_d   = '0;
               tx_state_d = TX_SEND;
            end
         end
         TX_SEND: begin
            put_outbound     = 1'b1;
            payload_outbound = tx_shift_q[PKT_W-1 -: FLIT_W];
            tx_shift_d       = tx_shift_q << FLIT_W;
            tx_cnt_d         = tx_cnt_q + 1'b1;
            if (tx_cnt_q == CNT_W'(NFLITS-1)) begin
               tx_last    = 1'b1;
               tx_cnt_d   = '0;
               tx_state_d = TX_IDLE;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_shift_d = rx_shift_q;
      rx_cnt_d   = rx_cnt_q;
      iq_push    = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (put_inbound && free_inbound) begin
               rx_shift_d = iq_wdata;
               rx_cnt_d   = CNT_W'(1);
               rx_state_d = RX_RECV;
            end
         end
         RX_RECV: begin
            if (!put_inbound) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_IDLE;
            end else if (rx_cnt_q == CNT_W'(NFLITS-1)) begin
               iq_push    = 1'b1;
               rx_cnt_d   = '0;
               rx_state_d = RX_IDLE;
            end else begin
               rx_shift_d = iq_wdata;
               rx_cnt_d   = rx_cnt_q + 1'b1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

`ifdef NODE_EP_STATS_EN
   logic [15:0] tx_pkt_cnt_q, rx_pkt_cnt_q;
   logic [7:0]  drop_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_pkt_cnt_q <= '0;
         rx_pkt_cnt_q <= '0;
         drop_cnt_q   <= '0;
      end else begin
         if (tx_last) tx_pkt_cnt_q <= tx_pkt_cnt_q + 1'b1;
         if (iq_push) rx_pkt_cnt_q <= rx_pkt_cnt_q + 1'b1;
         if (pkt_in_avail && oq_full && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 1'b1;
      end
   end

   assign tx_pkt_cnt = tx_pkt_cnt_q;
   assign rx_pkt_cnt = rx_pkt_cnt_q;
   assign drop_cnt   = drop_cnt_q;
`endif
endmodule

// File: tb/tb_node_endpoint_p.sv
// Self-checking bench for node_endpoint_p: flit and packet scoreboards plus directed timing checks.
// Define NODE_EP_STATS_EN to also check the statistics counters.

module tb_node_endpoint_p;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pkt_in = '0;
   logic        pkt_in_avail = 1'b0;
   logic        cQ_full;
   logic [31:0] pkt_out;
   logic        pkt_out_avail;
   logic        pkt_out_rdy = 1'b0;
   logic        free_outbound = 1'b0;
   logic        put_outbound;
   logic [7:0]  payload_outbound;
   logic        free_inbound;
   logic        put_inbound = 1'b0;
   logic [7:0]  payload_inbound = '0;
   logic        tx_state_dbg, rx_state_dbg;
`ifdef NODE_EP_STATS_EN
   logic [15:0] tx_pkt_cnt, rx_pkt_cnt;
   logic [7:0]  drop_cnt;
`endif

   logic [7:0]  exp_flit_q[$];
   logic [31:0] exp_pkt_q[$];
   logic [7:0]  mon_flit_e;
   logic [31:0] mon_pkt_e;
   int          n_cmp = 0;
   int          n_err = 0;

   node_endpoint_p #(.PKT_W(32), .FLIT_W(8), .OQ_DEPTH(4), .IQ_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .pkt_in(pkt_in), .pkt_in_avail(pkt_in_avail), .cQ_full(cQ_full),
      .pkt_out(pkt_out), .pkt_out_avail(pkt_out_avail), .pkt_out_rdy(pkt_out_rdy),
      .free_outbound(free_outbound), .put_outbound(put_outbound), .payload_outbound(payload_outbound),
      .free_inbound(free_inbound), .put_inbound(put_inbound), .payload_inbound(payload_inbound),
`ifdef NODE_EP_STATS_EN
      .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt), .drop_cnt(drop_cnt),
`endif
      .tx_state_o(tx_state_dbg), .rx_state_o(rx_state_dbg)
   );

   // Clock; inputs change 1ns after posedge, outputs are sampled on negedge.
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_flits(input logic [31:0] p);
      for (int k = 0; k < 4; k++) exp_flit_q.push_back(p[31-8*k -: 8]);
   endtask

   task automatic push_pkt(input logic [31:0] p, input bit accept);
      pkt_in       = p;
      pkt_in_avail = 1'b1;
      if (accept) exp_flits(p);
      tick();
      pkt_in_avail = 1'b0;
   endtask

   task automatic send_in(input logic [31:0] p, input int nfl);
      for (int k = 0; k < nfl; k++) begin
         put_inbound     = 1'b1;
         payload_inbound = p[31-8*k -: 8];
         tick();
      end
      put_inbound     = 1'b0;
      payload_inbound = '0;
   endtask

   task automatic wait_tx_drain(input string tag, input int budget);
      int n = 0;
      while (exp_flit_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, exp_flit_q.size(), 0);
      repeat (6) @(negedge clk);
   endtask

   task automatic wait_rx_drain(input string tag, input int budget);
      int n = 0;
      while (exp_pkt_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, exp_pkt_q.size(), 0);
      repeat (4) @(negedge clk);
   endtask

   // Outbound flit scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (put_outbound) begin
            if (exp_flit_q.size() == 0) chk("tx_unexpected_put", put_outbound, 0);
            else begin
               mon_flit_e = exp_flit_q.pop_front();
               chk("tx_flit", payload_outbound, mon_flit_e);
            end
         end else chk("tx_idle_payload", payload_outbound, 0);
      end
   end

   // Inbound packet scoreboard: compare on every accepted handshake.
   always @(negedge clk) begin
      if (!rst && pkt_out_avail && pkt_out_rdy) begin
         if (exp_pkt_q.size() == 0) chk("rx_unexpected_pkt", pkt_out_avail, 0);
         else begin
            mon_pkt_e = exp_pkt_q.pop_front();
            chk("rx_pkt", pkt_out, mon_pkt_e);
         end
      end
   end

   initial begin
      // Reset
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_put", put_outbound, 0);
      chk("rst_payload", payload_outbound, 0);
      chk("rst_cq_full", cQ_full, 0);
      chk("rst_pkt_out", pkt_out, 0);
      chk("rst_avail", pkt_out_avail, 0);
      chk("rst_free_in", free_inbound, 1);
`ifdef NODE_EP_STATS_EN
      chk("rst_tx_cnt", tx_pkt_cnt, 0);
      chk("rst_rx_cnt", rx_pkt_cnt, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
`endif

      // Single packet out, with latency
      tick();
      free_outbound = 1'b1;
      push_pkt(32'hA5123456, 1'b1);
      @(negedge clk);
      chk("t1_lat_idle", put_outbound, 0);
      @(negedge clk);
      chk("t1_lat_put", put_outbound, 1);
      wait_tx_drain("t1_drain", 20);
      chk("t1_put_after", put_outbound, 0);
`ifdef NODE_EP_STATS_EN
      chk("t1_tx_cnt", tx_pkt_cnt, 1);
`endif

      // Fill OQ, overflow, then drain
      tick();
      free_outbound = 1'b0;
      for (int i = 0; i < 5; i++) begin
         pkt_in       = 32'h10203040 + 32'h01010101 * i;
         pkt_in_avail = 1'b1;
         if (i < 4) exp_flits(pkt_in);
         @(negedge clk);
         chk("t2_full_before", cQ_full, (i == 4) ? 1 : 0);
         tick();
      end
      pkt_in_avail = 1'b0;
      @(negedge clk);
      chk("t2_full_after", cQ_full, 1);
      tick();
      free_outbound = 1'b1;
      wait_tx_drain("t2_drain", 60);
      chk("t2_cq_empty", cQ_full, 0);
`ifdef NODE_EP_STATS_EN
      chk("t2_tx_cnt", tx_pkt_cnt, 5);
      chk("t2_drop_cnt", drop_cnt, 1);
`endif

      // Inbound backpressure
      tick();
      pkt_out_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_pkt_q.push_back(32'hB0000000 + i);
         send_in(32'hB0000000 + i, 4);
      end
      @(negedge clk);
      chk("t3_free_in_full", free_inbound, 0);
      chk("t3_avail", pkt_out_avail, 1);
      chk("t3_head", pkt_out, 32'hB0000000);
      tick();
      send_in(32'hEEEEEEEE, 4);
      pkt_out_rdy = 1'b1;
      tick();
      pkt_out_rdy = 1'b0;
      @(negedge clk);
      chk("t3_free_in_back", free_inbound, 1);
      tick();
      pkt_out_rdy = 1'b1;
      wait_rx_drain("t3_drain", 20);
      chk("t3_avail_empty", pkt_out_avail, 0);

      // Truncated inbound packet, then a full one
      tick();
      pkt_out_rdy = 1'b0;
      send_in(32'hC3AABB00, 3);
      repeat (3) begin
         @(negedge clk);
         chk("t4_no_partial", pkt_out_avail, 0);
      end
      tick();
      send_in(32'hC3010203, 4);
      @(negedge clk);
      chk("t4_avail", pkt_out_avail, 1);
      chk("t4_pkt_out", pkt_out, 32'hC3010203);
      exp_pkt_q.push_back(32'hC3010203);
      tick();
      pkt_out_rdy = 1'b1;
      wait_rx_drain("t4_drain", 20);
`ifdef NODE_EP_STATS_EN
      chk("t4_rx_cnt", rx_pkt_cnt, 5);
`endif

      // Simultaneous push and pop at count 2
      tick();
      free_outbound = 1'b0;
      push_pkt(32'h51515151, 1'b1);
      push_pkt(32'h52525252, 1'b1);
      pkt_in        = 32'h53535353;
      pkt_in_avail  = 1'b1;
      free_outbound = 1'b1;
      exp_flits(32'h53535353);
      tick();
      pkt_in_avail  = 1'b0;
      free_outbound = 1'b0;
      @(negedge clk);
      chk("t5_full_cnt2", cQ_full, 0);
      push_pkt(32'h54545454, 1'b1);
      @(negedge clk);
      chk("t5_full_cnt3", cQ_full, 0);
      push_pkt(32'h55555555, 1'b1);
      @(negedge clk);
      chk("t5_full_cnt4", cQ_full, 1);
      push_pkt(32'h56565656, 1'b0);
      free_outbound = 1'b1;
      wait_tx_drain("t5_drain", 80);
`ifdef NODE_EP_STATS_EN
      chk("t5_tx_cnt", tx_pkt_cnt, 10);
      chk("t5_drop_cnt", drop_cnt, 2);
`endif

      // Reset in the middle of a packet
      tick();
      free_outbound = 1'b0;
      pkt_out_rdy   = 1'b0;
      send_in(32'h5A5A5A5A, 4);
      push_pkt(32'h11223344, 1'b1);
      push_pkt(32'h66778899, 1'b1);
      free_outbound = 1'b1;
      tick();  // IDLE->SEND
      tick();  // flit 0 cycle ends
      tick();  // flit 1 cycle ends
      rst = 1'b1;
      exp_flit_q.delete();
      exp_pkt_q.delete();
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_put", put_outbound, 0);
      chk("t6_cq_full", cQ_full, 0);
      chk("t6_avail", pkt_out_avail, 0);
      chk("t6_free_in", free_inbound, 1);
`ifdef NODE_EP_STATS_EN
      chk("t6_tx_cnt", tx_pkt_cnt, 0);
`endif
      repeat (3) begin
         @(negedge clk);
         chk("t6_quiet", put_outbound, 0);
      end
      tick();
      push_pkt(32'hDEADBEEF, 1'b1);
      exp_pkt_q.push_back(32'h0102A0B0);
      send_in(32'h0102A0B0, 4);
      pkt_out_rdy = 1'b1;
      wait_tx_drain("t6_tx_drain", 30);
      wait_rx_drain("t6_rx_drain", 30);
`ifdef NODE_EP_STATS_EN
      chk("t6_tx_cnt_after", tx_pkt_cnt, 1);
      chk("t6_rx_cnt_after", rx_pkt_cnt, 1);
      chk("t6_drop_cnt_after", drop_cnt, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
